// File: rtl/oh_iddr_rxctrl.sv
// Purpose: trains an IDDR lane on a two-beat pattern, picks the rise/fall pairing, emits aligned 2*DW words.
// Latency: candidate formed in cycle n is on dout after edge n+1; one word per cycle once locked.
// Backpressure: single-entry output register; a word arriving while full and not ready is dropped and sets sticky overflow.
// Optional feature: OH_IDDR_RXCTRL_TIMEOUT_EN adds a training timeout counter and an ERROR state.
module oh_iddr_rxctrl #(
    parameter int            DW      = 8,
    parameter logic [DW-1:0] TRAIN_A = DW'(8'hA5),
    parameter logic [DW-1:0] TRAIN_B = DW'(8'h5A),
    parameter int            LOCKCNT = 16,
    parameter int            TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            enable,
    input  logic            retrain,
    input  logic [DW-1:0]   q1,
    input  logic [DW-1:0]   q2,
    output logic            iddr_ce,
    output logic [2*DW-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            locked,
    output logic            swap,
    output logic            overflow,
    output logic            error
);

`ifdef OH_IDDR_RXCTRL_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, TRAIN, LOCKED, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, TRAIN, LOCKED} state_t;
`endif

    localparam logic [7:0]        LOCK_V  = 8'(LOCKCNT);
    localparam logic [2*DW-1:0]   PATTERN = {TRAIN_B, TRAIN_A};

    state_t          state, state_nxt;
    logic            swap_nxt;
    logic [DW-1:0]   q2_prev;
    logic [2*DW-1:0] w0, w1, word;
    logic [7:0]      cnt0, cnt1, cnt0_nxt, cnt1_nxt;
    logic            hit0, hit1, cnt_clr, word_vld;

    assign w0       = {q2, q1};
    assign w1       = {q1, q2_prev};
    assign word     = swap ? w1 : w0;
    assign iddr_ce  = (state == TRAIN) || (state == LOCKED);
    assign locked   = (state == LOCKED);
    assign word_vld = (state == LOCKED) && enable && !retrain;
    assign cnt_clr  = (state != TRAIN) || retrain || !enable;

    always_comb begin
        cnt0_nxt = (w0 == PATTERN) ? cnt0 + 8'd1 : 8'd0;
        cnt1_nxt = (w1 == PATTERN) ? cnt1 + 8'd1 : 8'd0;
        hit0     = (cnt0_nxt == LOCK_V);
        hit1     = (cnt1_nxt == LOCK_V);
    end

`ifdef OH_IDDR_RXCTRL_TIMEOUT_EN
    logic [15:0] tmo;
    logic        tmo_hit;
    assign tmo_hit = ((tmo + 16'd1) == 16'(TIMEOUT));
    assign error   = (state == ERROR);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)      tmo <= '0;
        else if (cnt_clr) tmo <= '0;
        else              tmo <= tmo + 16'd1;
    end
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        swap_nxt  = swap;
        if (!enable) begin
            state_nxt = IDLE;
        end else if (retrain) begin
            state_nxt = TRAIN;
        end else begin
            case (state)
                IDLE:   state_nxt = TRAIN;
                // Aligned pairing wins a simultaneous lock.
                TRAIN: begin
                    if (hit0) begin
                        state_nxt = LOCKED;
                        swap_nxt  = 1'b0;
                    end else if (hit1) begin
                        state_nxt = LOCKED;
                        swap_nxt  = 1'b1;
                    end
`ifdef OH_IDDR_RXCTRL_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_nxt = ERROR;
                    end
`endif
                end
                LOCKED: state_nxt = LOCKED;
`ifdef OH_IDDR_RXCTRL_TIMEOUT_EN
                ERROR:  state_nxt = ERROR;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            swap  <= 1'b0;
            cnt0  <= '0;
            cnt1  <= '0;
        end else begin
            state <= state_nxt;
            swap  <= swap_nxt;
            cnt0  <= cnt_clr ? 8'd0 : cnt0_nxt;
            cnt1  <= cnt_clr ? 8'd0 : cnt1_nxt;
        end
    end

    // Swapped candidate must not see stale data from before training started.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            q2_prev <= '0;
        else if (state_nxt == TRAIN && (state != TRAIN || retrain))
            q2_prev <= '0;
        else if (iddr_ce)
            q2_prev <= q2;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (!enable || retrain) begin
            dout_valid <= 1'b0;
        end else if (word_vld) begin
            if (!dout_valid || dout_ready) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else begin
                overflow   <= 1'b1;
            end
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: doc/oh_iddr_rxctrl.md
# oh_iddr_rxctrl

Receive-side controller for a DW-bit `oh_iddr` lane. It enables the IDDR and trains on a known two-beat pattern to decide the phase pairing of rising- and falling-edge samples. It then assembles aligned 2*DW-bit words and presents them on a valid/ready output. It sits between the IDDR and the link-layer receive logic.

## Interface
- DW, 8, IDDR lane width.
- TRAIN_A, 8'hA5, expected first-beat training value. DW bits.
- TRAIN_B, 8'h5A, expected second-beat training value. DW bits.
- LOCKCNT, 16, consecutive matching cycles required to lock. Range 1..255.
- TIMEOUT, 1024, maximum training cycles. Used only when the timeout feature is compiled in. Range 1..65535.

Ports:
- clk  in  1  clock, the same clock that drives the IDDR.
- nreset  in  1  reset, asynchronous, active low.
- enable  in  1  level; high runs the controller.
- retrain  in  1  single-cycle pulse; forces re-training.
- q1  in  DW  IDDR rising-edge sample.
- q2  in  DW  IDDR falling-edge sample.
- iddr_ce  out  1  clock enable to the IDDR.
- dout  out  2*DW  aligned word, {second beat, first beat}.
- dout_valid  out  1  dout holds a word.
- dout_ready  in  1  consumer accepts the word.
- locked  out  1  controller is in LOCKED.
- swap  out  1  selected phase: 0 = aligned, 1 = swapped.
- overflow  out  1  sticky; a word was dropped.
- error  out  1  training timed out. Held at 0 when the timeout feature is compiled out.

## Operation
- Internal register q2_prev holds the previous cycle's q2. Every cycle with iddr_ce=1, the block forms two candidate words:
  - Aligned candidate W0 = {q2, q1}.
  - Swapped candidate W1 = {q1, q2_prev}.
- States and transitions:
  - IDLE: iddr_ce=0 and all counters clear. Go to TRAIN when enable=1.
  - TRAIN: iddr_ce=1. Per cycle, if W0=={TRAIN_B,TRAIN_A}, increment the aligned match counter; otherwise clear it. The swapped match counter does the same using W1. When a counter reaches LOCKCNT, go to LOCKED and set swap (0 for the aligned counter, 1 for the swapped counter). If both reach LOCKCNT in the same cycle, aligned wins (swap=0).
  - LOCKED: iddr_ce=1 and locked=1. Every cycle, the selected candidate is a new word.
  - ERROR: only exists when the timeout feature is compiled in. iddr_ce=0 and error=1. Leave ERROR only on retrain or enable=0.
- enable=0 in any state: go to IDLE the next cycle. locked, dout_valid and error clear. overflow is kept.
- retrain=1 in any state with enable=1: go to TRAIN. Match counters, timeout counter, locked and error clear. dout_valid clears unless the word is being accepted in that cycle.
- Output register, single entry:
  - A new word loads into dout when dout_valid=0, or when dout_ready=1 in the same cycle.
  - If a word arrives while dout_valid=1 and dout_ready=0, the new word is dropped, dout is held, and overflow is set to 1.
  - overflow clears only on reset.
- Training words are never output. Words are produced only from LOCKED state.
- swap is held until the next lock and cleared by reset.

## Timing
- Reset values: iddr_ce=0, dout=0, dout_valid=0, locked=0, swap=0, overflow=0, error=0. State is IDLE.
- From enable rising at edge E: state is TRAIN and iddr_ce=1 after E+1.
- Lock: locked=1 one cycle after the cycle where the counter reaches LOCKCNT.
- Data latency: the candidate at cycle n appears on dout with dout_valid=1 after edge n+1.
- Throughput is one word per cycle. dout_ready must stay high to avoid drops.
- Handshake: a transfer occurs when dout_valid and dout_ready are both high at a rising edge. dout is stable while valid=1 and ready=0.
- The q2_prev register updates only while iddr_ce=1. It clears when entering TRAIN.

## Configuration
- OH_IDDR_RXCTRL_TIMEOUT_EN defined:
  - A 16-bit counter runs during TRAIN.
  - When it reaches TIMEOUT without a lock, the next state is ERROR and error=1.
- OH_IDDR_RXCTRL_TIMEOUT_EN undefined:
  - There is no timeout counter and no ERROR state.
  - TRAIN continues until lock or until enable deasserts. error is tied to 0.

## Test plan
- Aligned lock, DW=8, LOCKCNT=16: drive q1=A5, q2=5A for 20 cycles after enable. Required: locked=1 with swap=0 at cycle 17. Next, with q1=11, q2=22, dout=16'h2211.
- Swapped lock: drive q2 of cycle n-1 = A5 and q1 of cycle n = 5A. Required: locked=1 with swap=1. Next, with q2=33 then q1=44, dout=16'h4433.
- Mismatch in training: a single corrupt beat at match 10 resets the counter. Required: lock occurs 16 cycles after the corrupt beat, not earlier.
- Backpressure: locked, with dout_ready=0 for 2 cycles. Required: dout holds the first word, overflow=1, and the second word is dropped. With ready=1, streaming resumes with no duplicates.
- Timeout, macro defined with TIMEOUT=100: random q1/q2. Required: error=1 and iddr_ce=0 at cycle 101. A retrain pulse returns to TRAIN with error=0.
- Reset mid-stream: assert nreset low while locked with dout_valid=1. Required: all outputs are 0 immediately, including overflow.
